// File: rtl/bitstream_eval_ctrl.sv
// bitstream_eval_ctrl: reseeds a stochastic bitstream generator, enables it for WINDOW cycles and counts returned ones
module bitstream_eval_ctrl #(
  parameter int LENGTH = 8,
  parameter int WINDOW = 255,
  parameter int CW = $clog2(WINDOW + 1)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [LENGTH-1:0] req_x,
  input  logic              abort,
  output logic [LENGTH-1:0] gen_x,
  output logic              gen_reseed,
  output logic              gen_en,
  input  logic              stream_bit,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CW-1:0]     res_count,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, SEED, RUN, DONE} state_t;
  state_t state, nxt;
  logic [CW-1:0] ones, cnt;
  logic last, active;
  assign last = cnt == CW'(WINDOW - 1);
  assign active = state == SEED || state == RUN;
  // abort wins over the RUN->DONE transition
  always_comb
    nxt = state == IDLE ? (req_valid ? SEED : IDLE) :
          state == SEED ? (abort ? IDLE : RUN) :
          state == RUN  ? (abort ? IDLE : last ? DONE : RUN) :
                          (res_ready ? IDLE : DONE);
  // decoded outputs are registered from the next state so they track state exactly
  always_ff @(posedge clk)
    if (!n_rst) begin
      state      <= IDLE;
      gen_x      <= '0;
      res_count  <= '0;
      ones       <= '0;
      cnt        <= '0;
      req_ready  <= 1'b1;
      gen_reseed <= 1'b0;
      gen_en     <= 1'b0;
      res_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= nxt;
      req_ready  <= nxt == IDLE;
      gen_reseed <= nxt == SEED;
      gen_en     <= nxt == RUN;
      res_valid  <= nxt == DONE;
      busy       <= nxt != IDLE;
      if (state == IDLE && req_valid) gen_x <= req_x;
      if (state == SEED) begin
        ones      <= '0;
        cnt       <= '0;
        res_count <= '0;
      end
      if (state == RUN) begin
        ones <= ones + CW'(stream_bit);
        cnt  <= cnt + CW'(1);
      end
      if (state == RUN && last && !abort) res_count <= ones + CW'(stream_bit);
      if (active && abort) res_count <= '0;
    end
endmodule

// File: tb/tb_bitstream_eval_ctrl.sv
// tb_bitstream_eval_ctrl: vector table plus scoreboard of expected counts for bitstream_eval_ctrl
module tb_bitstream_eval_ctrl;
  localparam int LENGTH = 8;
  localparam int WINDOW = 16;
  localparam int CW = $clog2(WINDOW + 1);
  logic clk = 0;
  logic n_rst, req_valid, req_ready, abort, gen_reseed, gen_en, stream_bit, res_valid, res_ready, busy;
  logic [LENGTH-1:0] req_x, gen_x;
  logic [CW-1:0] res_count;
  typedef struct {
    logic [7:0]    x;
    logic [15:0]   mask;
    logic [CW-1:0] cnt;
    int            stall;
  } vec_t;
  vec_t v[9];
  logic [CW-1:0] exp_q[$];
  logic [15:0] cur_mask = 16'hFFFF;
  int k = 0;
  int vecs = 0;
  int errs = 0;
  bitstream_eval_ctrl #(.LENGTH(LENGTH), .WINDOW(WINDOW)) dut (
    .clk(clk), .n_rst(n_rst), .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x),
    .abort(abort), .gen_x(gen_x), .gen_reseed(gen_reseed), .gen_en(gen_en),
    .stream_bit(stream_bit), .res_valid(res_valid), .res_ready(res_ready),
    .res_count(res_count), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // stream driver: bit k of cur_mask in the k-th RUN cycle, 1 everywhere else
  always @(negedge clk)
    if (gen_en) begin
      stream_bit = cur_mask[k[3:0]];
      k++;
    end else begin
      stream_bit = 1'b1;
      if (gen_reseed) k = 0;
    end
  // scoreboard: compare each completed result handshake against the oldest expectation
  always @(negedge clk)
    if (n_rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL unexpected_result: got %0d expected none", res_count);
      end else check("res_count", 32'(res_count), 32'(exp_q.pop_front()));
    end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic accept(input logic [7:0] x);
    int t = 0;
    while (!req_ready && t < 60) begin
      tick();
      t++;
    end
    check("req_ready_wait", 32'(req_ready), 1);
    req_x = x;
    req_valid = 1;
    tick();
    req_valid = 0;
    req_x = ~x;
  endtask
  task automatic run_eval(input logic [7:0] x, input logic [15:0] mask, input logic [CW-1:0] cnt, input int stall);
    int lat, en, rs;
    logic [CW-1:0] held;
    cur_mask = mask;
    exp_q.push_back(cnt);
    res_ready = (stall == 0);
    accept(x);
    check("gen_x", 32'(gen_x), 32'(x));
    check("seed_reseed", 32'(gen_reseed), 1);
    check("seed_en", 32'(gen_en), 0);
    lat = 1;
    en = 0;
    rs = 0;
    while (!res_valid && lat < 40) begin
      tick();
      lat++;
      en += int'(gen_en);
      rs += int'(gen_reseed);
    end
    check("latency", 32'(lat), 18);
    check("en_cycles", 32'(en), 16);
    check("reseed_extra", 32'(rs), 0);
    check("gen_x_hold", 32'(gen_x), 32'(x));
    if (stall > 0) begin
      held = res_count;
      for (int i = 0; i < stall; i++) begin
        req_valid = ~i[0];
        tick();
        check("stall_valid", 32'(res_valid), 1);
        check("stall_count", 32'(res_count), 32'(held));
        check("stall_ready", 32'(req_ready), 0);
      end
      req_valid = 0;
      res_ready = 1;
    end
    tick();
    check("done_req_ready", 32'(req_ready), 1);
    check("done_busy", 32'(busy), 0);
    check("done_valid", 32'(res_valid), 0);
    tick();
    check("idle_busy", 32'(busy), 0);
  endtask
  task automatic check_idle(input string name);
    check({name, "_req_ready"}, 32'(req_ready), 1);
    check({name, "_busy"}, 32'(busy), 0);
    check({name, "_gen_en"}, 32'(gen_en), 0);
    check({name, "_reseed"}, 32'(gen_reseed), 0);
    check({name, "_valid"}, 32'(res_valid), 0);
    check({name, "_count"}, 32'(res_count), 0);
  endtask
  initial begin
    int seen;
    logic [15:0] r;
    v[0] = '{8'h80, 16'hFFFF, 16, 0};
    v[1] = '{8'h41, 16'h5555, 8, 0};
    v[2] = '{8'h00, 16'h0000, 0, 0};
    v[3] = '{8'hFF, 16'h8001, 2, 0};
    v[4] = '{8'h12, 16'h00FF, 8, 5};
    v[5] = '{8'hA5, 16'h1234, 5, 0};
    v[6] = '{8'h5A, 16'hF0F0, 8, 3};
    r = 16'($urandom);
    v[7] = '{8'h33, r, CW'($countones(r)), 0};
    r = 16'($urandom);
    v[8] = '{8'hC3, r, CW'($countones(r)), 2};
    n_rst = 0;
    req_valid = 0;
    req_x = 0;
    abort = 0;
    res_ready = 1;
    stream_bit = 1;
    tick();
    tick();
    n_rst = 1;
    check_idle("reset");
    check("reset_gen_x", 32'(gen_x), 0);
    for (int i = 0; i < 9; i++) run_eval(v[i].x, v[i].mask, v[i].cnt, v[i].stall);
    // abort in the 5th RUN cycle
    cur_mask = 16'hFFFF;
    accept(8'h77);
    for (int i = 0; i < 5; i++) tick();
    check("abort_in_run", 32'(gen_en), 1);
    abort = 1;
    tick();
    abort = 0;
    check_idle("abort");
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      seen += int'(res_valid);
    end
    check("abort_no_result", 32'(seen), 0);
    run_eval(8'h3C, 16'hFFFF, 16, 0);
    // reset in the 10th RUN cycle
    accept(8'h99);
    for (int i = 0; i < 10; i++) tick();
    check("rst_in_run", 32'(gen_en), 1);
    n_rst = 0;
    tick();
    n_rst = 1;
    check_idle("midrst");
    check("midrst_gen_x", 32'(gen_x), 0);
    run_eval(8'h66, 16'hFFFF, 16, 0);
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/bitstream_eval_ctrl.md
# bitstream_eval_ctrl

Sequencer for one stochastic bitstream generator and the network path it feeds. It accepts an evaluation request carrying an operand value and presents that value to the generator. It then reseeds the generator, enables it for a fixed window of cycles, and counts the `1`s returned on the stream under test. The result is delivered through a valid/ready handshake, giving higher-level logic a single operand-in, count-out interface to the bitstream network.

## Interface
- `LENGTH`, default 8: operand width; equals the generator LFSR width.
- `WINDOW`, default 255: number of generator-enabled cycles per evaluation; must be ≥1.
- `CW`, default `$clog2(WINDOW+1)`: result count width; derived, not overridden.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `n_rst`  in  1  reset, synchronous and active-low.
- `req_valid`  in  1  evaluation request present.
- `req_ready`  out  1  controller can accept a request.
- `req_x`  in  LENGTH  operand value for the request.
- `abort`  in  1  cancel the evaluation in progress.
- `gen_x`  out  LENGTH  comparison value driven to the generator.
- `gen_reseed`  out  1  one-cycle pulse; generator loads its seed.
- `gen_en`  out  1  generator advances its LFSR this cycle.
- `stream_bit`  in  1  stream bit under test, same-cycle with `gen_en`.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts the result.
- `res_count`  out  CW  number of `1`s sampled during the window.
- `busy`  out  1  high in SEED, RUN and DONE.

## Operation
- **State machine:** IDLE → SEED → RUN → DONE → IDLE.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`&`req_ready`: latch `req_x` into `gen_x` and go to SEED.
- **SEED** (exactly 1 cycle)
  - `gen_reseed`=1, `gen_en`=0.
  - Clear the ones counter and the cycle counter.
  - Go to RUN.
- **RUN**
  - `gen_en`=1.
  - Each cycle, add `stream_bit` to the ones counter and increment the cycle counter.
  - After the WINDOW-th RUN cycle, go to DONE.
- **DONE**
  - `res_valid`=1; `res_count` holds the ones counter.
  - On `res_ready`, go to IDLE.
- **Decoded outputs:** `req_ready`, `gen_reseed`, `gen_en`, `res_valid` and `busy` are decoded from the state only.
- **Held values:**
  - `gen_x` holds its latched value until the next accepted request.
  - `res_count` holds until the next SEED.
- **Width rule:** the ones counter and cycle counter are both CW bits. The maximum count is WINDOW, so no overflow or saturation logic is needed.
- **Abort**
  - In SEED or RUN: next state is IDLE; no result is produced and `res_count` is cleared.
  - In IDLE or DONE: ignored.
  - Abort takes priority over the RUN→DONE transition in the same cycle.
- **Requests:** `req_valid` outside IDLE is ignored and not queued.

## Timing
- **Reset:** `n_rst`=0 at a rising edge forces state=IDLE and `gen_x`=0, `res_count`=0, both counters=0. From the following cycle:
  - `req_ready`=1
  - `busy`=0, `gen_reseed`=0, `gen_en`=0, `res_valid`=0
- **Reset mid-operation:** same result as above; any partial count is discarded.
- **Request accept at edge T:**
  - SEED during cycle T+1.
  - RUN during cycles T+2 … T+1+WINDOW.
  - `res_valid` rises in cycle T+2+WINDOW.
- **Latency:** WINDOW+2 cycles from accept to `res_valid`.
- **Result handshake:** completes at the edge where `res_valid`&`res_ready`. `req_ready` is 1 in the next cycle.
- **Throughput:** minimum request-to-request spacing is WINDOW+3 cycles.
- **Result stall:** `res_valid` and `res_count` remain stable while `res_ready`=0.
- **Sampling:** `stream_bit` is sampled only in cycles where `gen_en`=1. Values in SEED, IDLE and DONE never affect the count.

## Test plan
Bench uses `WINDOW`=16, `LENGTH`=8.
1. Hold `n_rst`=0 for 2 cycles, then release → `req_ready`=1, `busy`=0, `gen_en`=0, `gen_reseed`=0, `res_valid`=0, `gen_x`=0, `res_count`=0.
2. Request `req_x`=0x80 with `stream_bit` held 1 and `res_ready`=1 → the following must all hold:
   - `gen_x`=0x80 from T+1.
   - `gen_reseed` high for exactly 1 cycle.
   - `gen_en` high for exactly 16 cycles.
   - `res_valid` at T+18 with `res_count`=16.
   - `req_ready`=1 at T+19.
3. `stream_bit` alternating 1,0,… starting with 1 in the first RUN cycle, and held at 1 during SEED → `res_count`=8.
4. Complete an evaluation with `res_ready`=0 for 5 cycles while pulsing `req_valid` → `res_valid` and `res_count` stay stable, `req_ready`=0, and no new request is accepted. Raising `res_ready` returns the controller to IDLE on the next cycle.
5. Assert `abort` in the 5th RUN cycle → `gen_en`=0 and `busy`=0 next cycle, no `res_valid` pulse, `res_count`=0. A new request then yields a fresh count of 16 with `stream_bit`=1.
6. Drive `n_rst`=0 for 1 cycle in the 10th RUN cycle → IDLE on the next cycle with all outputs at reset values. A following request with `stream_bit`=1 returns `res_count`=16.
